// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single main-memory port between the icache miss path and the
//   dcache miss/writeback path. Block transfers are serialised and the read
//   block is routed back to whichever cache owned the transfer.
//
//   Optional feature macro: MEM_ARB_RR_EN
//     defined   -> round-robin arbitration on a tie (last_grant register)
//     undefined -> fixed priority, dcache beats icache
//
// Ports
//   clk, reset       clock / synchronous active-high reset
//   i_read           icache block read request
//   i_address        icache block address
//   i_readdata       block returned to icache (held until next icache read)
//   i_busywait       icache stall
//   d_read, d_write  dcache block read / writeback request
//   d_address        dcache block address
//   d_writedata      dcache writeback block
//   d_readdata       block returned to dcache (held until next dcache read)
//   d_busywait       dcache stall
//   mem_read/write   registered memory strobes
//   mem_address      registered memory block address
//   mem_writedata    registered memory write block
//   mem_readdata     memory read block
//   mem_busywait     memory busy
//   arb_owner        00 none, 01 icache, 10 dcache
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic [1:0]         arb_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t state;
    logic   i_req;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

`ifdef MEM_ARB_RR_EN
    logic   last_grant;   // 0 = icache, 1 = dcache
`endif

    always_comb begin
        i_req = i_read;
        d_req = d_read | d_write;
`ifdef MEM_ARB_RR_EN
        // On a tie, the side that did not win last time goes first.
        grant_d = d_req & (~i_req | ~last_grant);
`else
        grant_d = d_req;
`endif
        grant_i = i_req & ~grant_d;
        // Only the owner, and only in RELEASE, sees its stall drop.
        i_busywait = i_req & ~((state == RELEASE) && (arb_owner == OWN_I));
        d_busywait = d_req & ~((state == RELEASE) && (arb_owner == OWN_D));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            arb_owner     <= OWN_NONE;
`ifdef MEM_ARB_RR_EN
            last_grant    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= GRANT_D;
                        arb_owner     <= OWN_D;
                        mem_address   <= d_address;
                        // read+write together is treated as a writeback
                        mem_write     <= d_write;
                        mem_read      <= ~d_write;
                        mem_writedata <= d_writedata;
`ifdef MEM_ARB_RR_EN
                        last_grant    <= 1'b1;
`endif
                    end else if (grant_i) begin
                        state       <= GRANT_I;
                        arb_owner   <= OWN_I;
                        mem_address <= i_address;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        last_grant  <= 1'b0;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!mem_busywait) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (mem_read) begin
                            if (state == GRANT_I)
                                i_readdata <= mem_readdata;
                            else
                                d_readdata <= mem_readdata;
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state     <= IDLE;
                    arb_owner <= OWN_NONE;
                end
                default: begin
                    state     <= IDLE;
                    arb_owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_busywait;
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_busywait;
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    logic [1:0]         arb_owner;

    int n_cmp = 0;
    int n_err = 0;

    // Simple memory model: busy for 'lat' cycles of a pending strobe.
    int unsigned lat  = 0;
    int unsigned mcnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read | mem_write) mcnt <= mcnt + 1;
        else                      mcnt <= 0;
    end

    assign mem_busywait = (mem_read | mem_write) && (mcnt < lat);

    mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .arb_owner(arb_owner)
    );

    localparam logic [BLOCK_W-1:0] BLK_I2 = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [BLOCK_W-1:0] BLK_A5 = {4{32'hA5A5A5A5}};
    localparam logic [BLOCK_W-1:0] BLK_X2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [BLOCK_W-1:0] BLK_X3 = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;
    localparam logic [BLOCK_W-1:0] BLK_X4 = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;

    task automatic do_reset();
        reset = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        mem_readdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        mem_readdata = '0; lat = 0;
        i_read = 1'b1; i_address = 28'h0000010;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
        n_cmp++; if (arb_owner !== 2'b00) begin n_err++; $display("FAIL rst_owner got %b exp 00", arb_owner); end
        n_cmp++; if (i_busywait !== 1'b1) begin n_err++; $display("FAIL rst_i_busywait got %b exp 1", i_busywait); end
        n_cmp++; if (i_readdata !== '0) begin n_err++; $display("FAIL rst_i_readdata got %h exp 0", i_readdata); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rst_release_strobe got %b exp 1", mem_read); end
        do_reset();
    endtask

    task automatic test_icache_read();
        int  n_strobe;
        bit  done;
        do_reset();
        lat = 4;
        mem_readdata = BLK_I2;
        i_read = 1'b1; i_address = 28'h0000010;
        n_strobe = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (mem_read) begin
                n_strobe++;
                if (n_strobe == 1) begin
                    n_cmp++; if (mem_address !== 28'h0000010) begin n_err++; $display("FAIL ird_address got %h exp 0000010", mem_address); end
                end
            end
            if (!i_busywait) done = 1;
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL ird_timeout got busy exp release"); end
        n_cmp++; if (n_strobe != 5) begin n_err++; $display("FAIL ird_strobe_cycles got %0d exp 5", n_strobe); end
        n_cmp++; if (i_readdata !== BLK_I2) begin n_err++; $display("FAIL ird_data got %h exp %h", i_readdata, BLK_I2); end
        n_cmp++; if (arb_owner !== 2'b01) begin n_err++; $display("FAIL ird_release_owner got %b exp 01", arb_owner); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL ird_release_strobe got %b exp 0", mem_read); end
        i_read = 1'b0;
        @(negedge clk);
        n_cmp++; if (arb_owner !== 2'b00) begin n_err++; $display("FAIL ird_idle_owner got %b exp 00", arb_owner); end
    endtask

    task automatic test_back_to_back();
        int  i_drops;
        bit  done;
        do_reset();
        lat = 2;
        mem_readdata = BLK_X2;
        d_write = 1'b1; d_address = 28'h0000020; d_writedata = BLK_A5;
        i_read = 1'b1; i_address = 28'h0000040;
        @(negedge clk);
        n_cmp++; if (arb_owner !== 2'b10) begin n_err++; $display("FAIL b2b_first_owner got %b exp 10", arb_owner); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_err++; $display("FAIL b2b_write_strobes got %b exp 01", {mem_read, mem_write}); end
        n_cmp++; if (mem_address !== 28'h0000020) begin n_err++; $display("FAIL b2b_d_address got %h exp 0000020", mem_address); end
        n_cmp++; if (mem_writedata !== BLK_A5) begin n_err++; $display("FAIL b2b_writedata got %h exp %h", mem_writedata, BLK_A5); end
        i_drops = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (!i_busywait) i_drops++;
            if (!d_busywait) done = 1;
            else @(negedge clk);
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL b2b_d_timeout got busy exp release"); end
        n_cmp++; if (d_readdata !== '0) begin n_err++; $display("FAIL b2b_write_no_capture got %h exp 0", d_readdata); end
        d_write = 1'b0;
        @(negedge clk);
        if (!i_busywait) i_drops++;
        n_cmp++; if (arb_owner !== 2'b00) begin n_err++; $display("FAIL b2b_idle_gap got %b exp 00", arb_owner); end
        @(negedge clk);
        if (!i_busywait) i_drops++;
        n_cmp++; if (arb_owner !== 2'b01) begin n_err++; $display("FAIL b2b_second_owner got %b exp 01", arb_owner); end
        n_cmp++; if (mem_address !== 28'h0000040) begin n_err++; $display("FAIL b2b_i_address got %h exp 0000040", mem_address); end
        n_cmp++; if (i_drops != 0) begin n_err++; $display("FAIL b2b_i_stall got %0d drops exp 0", i_drops); end
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (!i_busywait) done = 1;
        end
        n_cmp++; if (i_readdata !== BLK_X2) begin n_err++; $display("FAIL b2b_i_data got %h exp %h", i_readdata, BLK_X2); end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic [1:0] seen [4];
        logic [1:0] exp_o [4];
        logic [1:0] prev;
        int         n;
`ifdef MEM_ARB_RR_EN
        exp_o[0] = 2'b10; exp_o[1] = 2'b01; exp_o[2] = 2'b10; exp_o[3] = 2'b01;
`else
        exp_o[0] = 2'b10; exp_o[1] = 2'b10; exp_o[2] = 2'b10; exp_o[3] = 2'b10;
`endif
        do_reset();
        lat = 1;
        mem_readdata = BLK_X3;
        d_read = 1'b1; d_address = 28'h0000100;
        i_read = 1'b1; i_address = 28'h0000200;
        prev = 2'b00; n = 0;
        for (int k = 0; k < 4; k++) seen[k] = 2'b00;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            if (arb_owner != 2'b00 && prev == 2'b00) begin
                seen[n] = arb_owner;
                n++;
            end
            prev = arb_owner;
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seen[k] !== exp_o[k]) begin n_err++; $display("FAIL arb_grant%0d got %b exp %b", k, seen[k], exp_o[k]); end
        end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset();
        lat = 0;
        mem_readdata = BLK_X3;
        d_read = 1'b1; d_address = 28'h0000030;
        #1;
        n_cmp++; if (d_busywait !== 1'b1) begin n_err++; $display("FAIL zw_idle_busy got %b exp 1", d_busywait); end
        @(negedge clk);
        n_cmp++; if (d_busywait !== 1'b1) begin n_err++; $display("FAIL zw_grant_busy got %b exp 1", d_busywait); end
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL zw_grant_strobe got %b exp 1", mem_read); end
        @(negedge clk);
        n_cmp++; if (d_busywait !== 1'b0) begin n_err++; $display("FAIL zw_release_busy got %b exp 0", d_busywait); end
        n_cmp++; if (d_readdata !== BLK_X3) begin n_err++; $display("FAIL zw_data got %h exp %h", d_readdata, BLK_X3); end
        d_read = 1'b0;
        mem_readdata = BLK_X4;
        @(negedge clk);
        n_cmp++; if (d_readdata !== BLK_X3) begin n_err++; $display("FAIL zw_hold got %h exp %h", d_readdata, BLK_X3); end
        n_cmp++; if (i_readdata !== '0) begin n_err++; $display("FAIL zw_i_untouched got %h exp 0", i_readdata); end
    endtask

    task automatic test_reset_mid_transfer();
        bit done;
        do_reset();
        lat = 0;
        mem_readdata = BLK_X4;
        i_read = 1'b1; i_address = 28'h0000050;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!i_busywait) done = 1;
        end
        i_read = 1'b0;
        @(negedge clk);
        lat = 100;
        i_read = 1'b1; i_address = 28'h0000060;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rmid_pending_strobe got %b exp 1", mem_read); end
        n_cmp++; if (i_readdata !== BLK_X4) begin n_err++; $display("FAIL rmid_prev_data got %h exp %h", i_readdata, BLK_X4); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_strobe got %b exp 0", mem_read); end
        n_cmp++; if (arb_owner !== 2'b00) begin n_err++; $display("FAIL rmid_owner got %b exp 00", arb_owner); end
        n_cmp++; if (i_readdata !== '0) begin n_err++; $display("FAIL rmid_readdata got %h exp 0", i_readdata); end
        n_cmp++; if (i_busywait !== 1'b1) begin n_err++; $display("FAIL rmid_busywait got %b exp 1", i_busywait); end
        reset = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_back_to_back();
        test_arbitration();
        test_zero_wait();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
